wb_commit_queue: RTL
====================

# wb_commit_queue

Writeback commit queue feeding the CPU register file's single write port. Accepts register writeback requests from the execute/memory stages over a valid/ready handshake, buffers them in order in a small FIFO, and drains one entry per cycle as a registered `wb_en`/`W_rd_index`/`wb_data` write. Because writes are deferred, it also provides forwarding for the two register-file read indices, so readers see pending, not-yet-committed values.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: writeback request valid.
- `in_ready` out 1: queue can accept; equals `count < DEPTH`.
- `in_rd` in 5: destination register index.
- `in_data` in XLEN: writeback value.
- `drain_hold` in 1: 1 = do not pop this cycle (debug halt/stall).
- `wb_en` out 1: register-file write enable (registered).
- `W_rd_index` out 5: register-file write index (registered).
- `wb_data` out XLEN: register-file write data (registered).
- `rs1_index`, `rs2_index` in 5: read indices being presented to the register file.
- `rs1_hit`, `rs2_hit` out 1: pending write exists for that index.
- `rs1_fwd_data`, `rs2_fwd_data` out XLEN: forwarded value, valid when hit.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Reset (`rst`=0, async): `count`=0, `empty`=1, `in_ready`=1, `wb_en`=0, `W_rd_index`=0, `wb_data`=0, head/tail pointers=0, all pending entries discarded. Hits are 0 while in reset.
- **Enqueue:** fires on a rising edge with `in_valid && in_ready`. The entry {`in_rd`, `in_data`} is written at the tail, and the tail advances mod DEPTH.
- **Enqueue with `in_rd`==0:** the handshake completes, but the request is dropped. Nothing is enqueued, and `count` is unchanged.
- **Pop:** fires on a rising edge with `!empty && !drain_hold`. The head entry is loaded into the output registers, `wb_en`=1, and the head advances mod DEPTH.
- **No pop on an edge:** `wb_en`←0. `W_rd_index` and `wb_data` hold their last value.
- **Simultaneous enqueue and pop:** `count` is unchanged. When full, `in_ready`=0 for that cycle (no pass-through), so enqueue cannot fire.
- **Order:** writes commit strictly in acceptance order. Multiple pending writes to the same index are all committed, so the last one wins in the register file.
- **Forwarding:** per read port, combinational, with this priority:
  1. Index 0: hit=0, data=0.
  2. Youngest valid FIFO entry with matching rd.
  3. Output register, if `wb_en`=1 and `W_rd_index` matches. This write lands at the end of the current cycle and is not yet visible to the register-file read.
  4. Otherwise hit=0 and data=0.
- Pointer wrap uses an extra occupancy count rather than a pointer MSB. `count` never exceeds DEPTH, and never underflows.

## Timing
- Latency: an entry accepted at edge N into an empty queue with `drain_hold`=0 is popped at edge N+1. `wb_en`=1 during cycle N+1→N+2, and the register file captures it at edge N+2.
- Throughput: one enqueue and one commit per cycle, sustained.
- `in_ready`, `count`, and `empty` are derived from registered state only. They do not depend on `in_valid` or `drain_hold` in the same cycle.
- Forwarding outputs have a combinational path from `rs*_index` and registered state only.
- Reset asserted mid-burst: outputs clear immediately (asynchronously), and no partial write is emitted after release.
- `drain_hold` toggling: each cycle with `drain_hold`=1 produces no pop. Entries are kept, and accepts continue until full.

## Test plan
- **Single write:** after reset, enqueue rd=5, data=0xDEADBEEF. Required: `wb_en`=1 with `W_rd_index`=5, `wb_data`=0xDEADBEEF exactly one cycle after the pop edge, then `wb_en`=0 and `empty`=1.
- **Fill and drain:** with `drain_hold`=1, enqueue rd=1..4 with data 0x11..0x44. Required: `count`=4, `in_ready`=0, and a fifth request stalls. Release the hold: four consecutive `wb_en` cycles in the order 1,2,3,4, and the stalled request is accepted once a slot frees.
- **Forwarding priority:** pending entries rd=7/0xA, then rd=7/0xB, with the output register holding rd=7/0x9. Set `rs1_index`=7. Required: `rs1_hit`=1, `rs1_fwd_data`=0xB. Set `rs2_index`=0. Required: `rs2_hit`=0, data=0.
- **x0 drop:** enqueue rd=0, data=0x1234 with `in_valid`=1. Required: `in_ready`=1 (handshake completes), `count` stays 0, and `wb_en` never asserts.
- **Simultaneous enqueue and pop with wrap-around:** stream 10 back-to-back writes with `drain_hold`=0. Required: `count` stays ≤1, all 10 commit in order, and pointers wrap cleanly past DEPTH.
- **Async reset mid-operation:** with 3 entries pending and `wb_en`=1, pull `rst` low between edges. Required: `wb_en`=0, `count`=0, and hits=0 immediately. After release, no stale entry is ever written.

Source files
------------

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers register writebacks in order, drains one per cycle
// into a registered write port, and forwards pending values to two read ports.
module wb_commit_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rd,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   drain_hold,
  output logic                   wb_en,
  output logic [4:0]             W_rd_index,
  output logic [XLEN-1:0]        wb_data,
  input  logic [4:0]             rs1_index,
  input  logic [4:0]             rs2_index,
  output logic                   rs1_hit,
  output logic                   rs2_hit,
  output logic [XLEN-1:0]        rs1_fwd_data,
  output logic [XLEN-1:0]        rs2_fwd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_wb_en;
  logic [4:0]      r_wb_idx;
  logic [XLEN-1:0] r_wb_data;

  logic w_push;
  logic w_pop;

  assign in_ready   = (r_count < CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign wb_en      = r_wb_en;
  assign W_rd_index = r_wb_idx;
  assign wb_data    = r_wb_data;

  // Writes to x0 complete the handshake but are never stored.
  assign w_push = in_valid && in_ready && (in_rd != '0);
  assign w_pop  = !empty && !drain_hold;

  // Entry validity comes from head/count, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wb_en   <= 1'b0;
      r_wb_idx  <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head    <= r_head + 1'b1;
        r_wb_en   <= 1'b1;
        r_wb_idx  <= r_rd[r_head];
        r_wb_data <= r_data[r_head];
      end else begin
        r_wb_en   <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match overrides; the output
  // register is only consulted when no queued entry matches.
  function automatic logic [XLEN:0] f_fwd(input logic [4:0] idx);
    logic          hit;
    logic [XLEN-1:0] d;
    logic [PW-1:0] slot;
    hit = 1'b0;
    d   = '0;
    if (idx != '0) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot = r_head + PW'(k);
        if ((CW'(k) < r_count) && (r_rd[slot] == idx)) begin
          hit = 1'b1;
          d   = r_data[slot];
        end
      end
      if (!hit && r_wb_en && (r_wb_idx == idx)) begin
        hit = 1'b1;
        d   = r_wb_data;
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {rs1_hit, rs1_fwd_data} = f_fwd(rs1_index);
    {rs2_hit, rs2_fwd_data} = f_fwd(rs2_index);
  end

endmodule
